nes_reader: RTL and testbench

//  Sequences the NES controller's 4021 shift register (latch, pulse, data), once per frame.

---
 rtl/nes_pkg.sv | 23 ++
 rtl/nes_tick_gen.sv | 28 ++
 rtl/nes_reader.sv | 163 ++++++++++++++++
 tb/tb_nes_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      LOW,
      PULSE,
      DONE
   } nes_state_t;

   localparam int unsigned NES_NUM_BITS = 8;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_tick_gen.sv
// Reloadable down-counter; expire is high while the count sits at zero.
module nes_tick_gen
   import nes_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expire
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/nes_reader.sv
// NES 4021 controller reader: latch/pulse sequencing once per frame, registered button vector.
// Optional NES_DEBOUNCE_EN: commit a frame only when it matches the previous capture.
module nes_reader
   import nes_pkg::*;
#(
   parameter int unsigned HALF_PERIOD  = 72,
   parameter int unsigned FRAME_CYCLES = 200000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    nes_data,
   output logic                    nes_latch,
   output logic                    nes_pulse,
   output logic [NES_NUM_BITS-1:0] buttons_n,
   output logic                    frame_valid,
   output logic                    busy
);

   localparam int unsigned TW = $clog2(2 * HALF_PERIOD);
   localparam int unsigned FW = $clog2(FRAME_CYCLES);
   localparam int unsigned IW = $clog2(NES_NUM_BITS);

   localparam logic [TW-1:0] LATCH_LD   = TW'(2 * HALF_PERIOD - 1);
   localparam logic [TW-1:0] HALF_LD    = TW'(HALF_PERIOD - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NES_NUM_BITS - 1);

   nes_state_t              state, state_nx;
   logic                    sync1, sync2;
   logic [FW-1:0]           frame_cnt;
   logic                    frame_start;
   logic [IW-1:0]           idx;
   logic [NES_NUM_BITS-1:0] sreg;
   logic                    tick_load;
   logic [TW-1:0]           tick_val;
   logic                    tick_exp;
   logic                    commit;

   nes_tick_gen #(
      .WIDTH (TW)
   ) u_tick (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tick_load),
      .load_val (tick_val),
      .expire   (tick_exp)
   );

   // Idle level of the pin is high (pull-up), so the synchronizer resets to 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= nes_data;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (frame_cnt == FRAME_LAST) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt + FW'(1);
      end
   end

   assign frame_start = (frame_cnt == FRAME_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      tick_load = 1'b0;
      tick_val  = HALF_LD;
      unique case (state)
         IDLE: begin
            if (frame_start) begin
               state_nx  = LATCH;
               tick_load = 1'b1;
               tick_val  = LATCH_LD;
            end
         end
         LATCH: begin
            if (tick_exp) begin
               state_nx  = LOW;
               tick_load = 1'b1;
            end
         end
         LOW: begin
            if (tick_exp) begin
               if (idx == LAST_IDX) begin
                  state_nx = DONE;
               end else begin
                  state_nx  = PULSE;
                  tick_load = 1'b1;
               end
            end
         end
         PULSE: begin
            if (tick_exp) begin
               state_nx  = LOW;
               tick_load = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef NES_DEBOUNCE_EN
   logic [NES_NUM_BITS-1:0] prev;
   logic                    prev_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev    <= '1;
         prev_ok <= 1'b0;
      end else if (state == DONE) begin
         prev    <= sreg;
         prev_ok <= 1'b1;
      end
   end

   assign commit = prev_ok && (sreg == prev);
`else
   assign commit = 1'b1;
`endif

   // Pin strobes decode the next state so they are flop outputs aligned with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx         <= '0;
         sreg        <= '1;
         nes_latch   <= 1'b0;
         nes_pulse   <= 1'b0;
         busy        <= 1'b0;
         buttons_n   <= '1;
         frame_valid <= 1'b0;
      end else begin
         nes_latch   <= (state_nx == LATCH);
         nes_pulse   <= (state_nx == PULSE);
         busy        <= (state_nx != IDLE);
         frame_valid <= 1'b0;
         if (state == LATCH && tick_exp) idx <= '0;
         if (state == PULSE && tick_exp) idx <= idx + IW'(1);
         if (state == LOW && tick_exp) sreg[idx] <= sync2;
         if (state == DONE && commit) begin
            buttons_n   <= sreg;
            frame_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nes_reader.sv
// Directed bench for nes_reader with a behavioural 4021 controller model.
`timescale 1ns/1ps
module tb_nes_reader;

   localparam int unsigned HP = 4;
   localparam int unsigned FC = 100;
`ifdef NES_DEBOUNCE_EN
   localparam int BUDGET = 400;
`else
   localparam int BUDGET = 200;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       nes_data;
   logic       nes_latch, nes_pulse, frame_valid, busy;
   logic [7:0] buttons_n;

   logic [7:0] pattern = 8'hFF;
   logic [7:0] sh = 8'hFF;
   logic       man_mode = 1'b0;
   logic       man_val = 1'b1;
   logic       toggle_en = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, rise_cyc = 0, last_fv = 0, fv_lat = 0, fv_gap = 0, fv_count = 0;
   int latch_len = 0, npulse = 0, pw = 0, pulse_bad = 0, overlap = 0;
   int n0 = 0;
   logic latch_q = 1'b0, pulse_q = 1'b0;
   logic [7:0] exp_bits = 8'hFF;
   logic hist [256];

   logic [7:0] pats   [3] = '{8'hDF, 8'hDF, 8'hBF};
`ifdef NES_DEBOUNCE_EN
   int         exp_sb [3] = '{0, 1, 0};
   logic [7:0] exp_bt [3] = '{8'hFF, 8'hDF, 8'hDF};
`else
   int         exp_sb [3] = '{1, 1, 1};
   logic [7:0] exp_bt [3] = '{8'hDF, 8'hDF, 8'hBF};
`endif

   nes_reader #(
      .HALF_PERIOD  (HP),
      .FRAME_CYCLES (FC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .nes_data    (nes_data),
      .nes_latch   (nes_latch),
      .nes_pulse   (nes_pulse),
      .buttons_n   (buttons_n),
      .frame_valid (frame_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // 4021 model: parallel load on latch, shift toward the pin on pulse, pull-up fills ones.
   always @(posedge nes_latch) sh = pattern;
   always @(posedge nes_pulse) sh = {1'b1, sh[7:1]};
   assign nes_data = man_mode ? man_val : sh[0];

   always @(posedge clk) begin
      if (toggle_en) begin
         #1 man_val = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      if (nes_latch && nes_pulse) overlap++;
      if (nes_latch && !latch_q) begin
         rise_cyc  = cyc;
         latch_len = 0;
         npulse    = 0;
         pulse_bad = 0;
      end
      if (nes_latch) latch_len++;
      if (nes_pulse && !pulse_q) begin
         if (npulse < 8) exp_bits[npulse] = hist[(cyc - 2) % 256];
         npulse++;
         pw = 0;
      end
      if (nes_pulse) pw++;
      if (!nes_pulse && pulse_q && pw != HP) pulse_bad++;
      if (frame_valid) begin
         fv_count++;
         fv_lat      = cyc - rise_cyc;
         fv_gap      = cyc - last_fv;
         last_fv     = cyc;
         exp_bits[7] = hist[(cyc - 2) % 256];
      end
      hist[(cyc + 1) % 256] = nes_data;
      latch_q = nes_latch;
      pulse_q = nes_pulse;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_for(input int sel, input logic lvl, input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(negedge clk);
         #1;
         hit = (((sel == 0) ? busy : frame_valid) == lvl);
      end
      if (!hit) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      bit found;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_latch", nes_latch, 0);
      chk("rst_pulse", nes_pulse, 0);
      chk("rst_buttons", buttons_n, 8'hFF);
      chk("rst_fv", frame_valid, 0);
      chk("rst_busy", busy, 0);
      reset_n = 1'b1;

      // A and Up pressed
      pattern = 8'hEE;
      wait_for(1, 1'b1, BUDGET, "t1_fv_timeout");
      chk("t1_buttons", buttons_n, 8'hEE);
      chk("t1_latency", fv_lat, 69);
      chk("t2_latch_len", latch_len, 8);
      chk("t2_pulse_count", npulse, 7);
      chk("t2_pulse_width_bad", pulse_bad, 0);
      @(negedge clk);
      #1;
      chk("t1_fv_one_cycle", frame_valid, 0);

      // unplugged controller
      pattern = 8'hFF;
      wait_for(1, 1'b1, BUDGET, "t4_fv1_timeout");
      chk("t4_buttons1", buttons_n, 8'hFF);
      wait_for(1, 1'b0, 5, "t4_fv_low_timeout");
      wait_for(1, 1'b1, FC + 10, "t4_fv2_timeout");
      chk("t4_fv_gap", fv_gap, FC);
      chk("t4_buttons2", buttons_n, 8'hFF);

      // Down, Down, Left from a fresh reset
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pattern = pats[i];
         n0 = fv_count;
         wait_for(0, 1'b1, FC + 20, $sformatf("t5_busy_rise_%0d", i));
         wait_for(0, 1'b0, FC, $sformatf("t5_busy_fall_%0d", i));
         chk($sformatf("t5_strobes_%0d", i), fv_count - n0, exp_sb[i]);
         chk($sformatf("t5_buttons_%0d", i), buttons_n, exp_bt[i]);
      end

      // reset while the bit-3 pulse is high
      found = 1'b0;
      for (int k = 0; k < 2 * FC && !found; k++) begin
         @(negedge clk);
         #1;
         found = nes_pulse && (npulse == 4);
      end
      chk("t3_found_pulse3", found, 1);
      reset_n = 1'b0;
      #1;
      chk("t3_latch", nes_latch, 0);
      chk("t3_pulse", nes_pulse, 0);
      chk("t3_buttons", buttons_n, 8'hFF);
      chk("t3_busy", busy, 0);
      chk("t3_fv", frame_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      n0 = fv_count;
      repeat (160) @(negedge clk);
      #1;
      chk("t3_no_early_fv", fv_count - n0, 0);
      wait_for(1, 1'b1, BUDGET, "t3_fv_timeout");
      chk("t3_buttons_after", buttons_n, 8'hBF);

      // pin toggled just after each clock edge
      man_mode  = 1'b1;
      toggle_en = 1'b1;
      wait_for(0, 1'b1, FC + 20, "t6_busy_rise");
      wait_for(0, 1'b0, FC, "t6_busy_fall");
      toggle_en = 1'b0;
      chk("t6_no_x", $isunknown(buttons_n), 0);
`ifndef NES_DEBOUNCE_EN
      chk("t6_sync_value", buttons_n, exp_bits);
`endif

      chk("t2_no_overlap", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
